// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module   : rv32i_pkg
// Purpose  : Shared RV32I constants, fetch FSM encoding and base opcodes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } fetch_state_e;

    // Major opcodes (instr[6:0]) consumed by decode
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_pc_next.sv
// ============================================================================
// Module   : pc_next
// Purpose  : Next-PC select: aligned redirect, sequential +4, or hold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_load,
    input  logic            i_redirect,
    input  logic [XLEN-3:0] i_redirect_base,
    output logic [XLEN-1:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_pc;
        if (i_redirect) begin
            o_next_pc = {i_redirect_base, 2'b00};
        end else if (i_load) begin
            o_next_pc = i_pc + 32'd4;
        end
    end

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Purpose  : RV32I fetch stage: PC, ROM addressing and IF/ID handshake reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 62,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        misalign_err
);

    import rv32i_pkg::*;

    localparam logic [29:0] c_rom_words = 30'(ROM_WORDS);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next_pc;
    logic            w_redirect;
    logic            w_load;
    logic [XLEN-1:0] w_fetch_word;

    assign rom_addr   = r_pc;
    assign w_redirect = redirect_valid && (r_state != BOOT);
    assign w_load     = (r_state == RUN) && fetch_en && (!if_valid || if_ready)
                        && !redirect_valid;

    // Word index compare covers wrap-around too: high addresses are out of range
    assign w_fetch_word = (r_pc[31:2] < c_rom_words) ? rom_data : NOP_INSTR;

    pc_next u_pc_next (
        .i_pc            (r_pc),
        .i_load          (w_load),
        .i_redirect      (w_redirect),
        .i_redirect_base (redirect_pc[31:2]),
        .o_next_pc       (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            if_valid     <= 1'b0;
            if_instr     <= NOP_INSTR;
            if_pc        <= 32'h0000_0000;
            if_pc_plus4  <= 32'h0000_0004;
            misalign_err <= 1'b0;
        end else begin
            r_pc <= w_next_pc;

            case (r_state)
                BOOT:    r_state <= fetch_en ? RUN : PAUSE;
                RUN:     if (!fetch_en) r_state <= PAUSE;
                PAUSE:   if (fetch_en)  r_state <= RUN;
                default: r_state <= BOOT;
            endcase

            // Redirect flushes the IF/ID register regardless of if_ready
            if (w_redirect) begin
                if_valid <= 1'b0;
                if (redirect_pc[1:0] != 2'b00) begin
                    misalign_err <= 1'b1;
                end
            end else if (w_load) begin
                if_valid    <= 1'b1;
                if_instr    <= w_fetch_word;
                if_pc       <= r_pc;
                if_pc_plus4 <= r_pc + 32'd4;
            end else if (if_valid && if_ready) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
